// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   ls_mode_t    - 3-bit access size/sign code presented on ls_src
//   lsu_state_t  - LSU handshake FSM states
//   legalize_mode, size_bytes, be_mask, is_signed - decode helpers
package lsu_pkg;

  typedef enum logic [2:0] {
    LS_W  = 3'b000,
    LS_H  = 3'b001,
    LS_B  = 3'b010,
    LS_HU = 3'b011,
    LS_BU = 3'b100,
    LS_D  = 3'b101,
    LS_WU = 3'b110
  } ls_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  // Doubleword and unsigned-word codes only exist on a 64-bit datapath;
  // every code that has no meaning for the current width (including 3'b111)
  // collapses to a plain word access.
  function automatic ls_mode_t legalize_mode(input logic [2:0] code, input bit is64);
    case (code)
      3'b001:  return LS_H;
      3'b010:  return LS_B;
      3'b011:  return LS_HU;
      3'b100:  return LS_BU;
      3'b101:  return is64 ? LS_D : LS_W;
      3'b110:  return is64 ? LS_WU : LS_W;
      default: return LS_W;
    endcase
  endfunction

  function automatic int size_bytes(input ls_mode_t mode);
    case (mode)
      LS_B, LS_BU: return 1;
      LS_H, LS_HU: return 2;
      LS_D:        return 8;
      default:     return 4;
    endcase
  endfunction

  function automatic logic [7:0] be_mask(input ls_mode_t mode, input logic [2:0] off);
    logic [7:0] mask;
    case (mode)
      LS_B, LS_BU: mask = 8'h01;
      LS_H, LS_HU: mask = 8'h03;
      LS_D:        mask = 8'hFF;
      default:     mask = 8'h0F;
    endcase
    return mask << off;
  endfunction

  // Word loads sign-extend; on a 32-bit datapath that is a no-op because
  // the word already fills the register.
  function automatic logic is_signed(input ls_mode_t mode);
    return (mode == LS_H) || (mode == LS_B) || (mode == LS_W);
  endfunction

endpackage

// File: rtl/lsu_mem_if_align.sv
// lsu_align: purely combinational lane logic for the LSU.
//   mode_i   - legalised access mode
//   off_i    - byte offset inside the bus word (already size-aligned)
//   wdata_i  - store source register
//   rdata_i  - raw memory read data
//   be_o     - byte enables for the access
//   wdata_o  - store data replicated across every byte lane
//   rdata_o  - load data shifted down, truncated and extended
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8,
  parameter int OFF_W  = $clog2(XLEN / 8)
) (
  input  ls_mode_t           mode_i,
  input  logic [OFF_W-1:0]   off_i,
  input  logic [XLEN-1:0]    wdata_i,
  input  logic [XLEN-1:0]    rdata_i,
  output logic [STRB_W-1:0]  be_o,
  output logic [XLEN-1:0]    wdata_o,
  output logic [XLEN-1:0]    rdata_o
);

  int               sizeInt;
  logic [7:0]       beFull;
  logic [XLEN-1:0]  shifted;
  logic             signExt;

  assign sizeInt = size_bytes(mode_i);
  assign beFull  = be_mask(mode_i, 3'(off_i));
  assign be_o    = beFull[STRB_W-1:0];

  // Lane i of the bus carries byte (i mod size) of the source register, so
  // whichever lanes the byte enables select see the right bytes.
  always_comb begin
    wdata_o = '0;
    for (int i = 0; i < STRB_W; i++) begin
      wdata_o[i*8 +: 8] = wdata_i[(i % sizeInt)*8 +: 8];
    end
  end

  assign shifted = rdata_i >> {off_i, 3'b000};
  assign signExt = is_signed(mode_i) & shifted[sizeInt*8-1];

  // Keep the low size*8 bits of the shifted word and fill the rest with
  // either the top data bit or zero.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      rdata_o[i] = (i < sizeInt*8) ? shifted[i] : signExt;
    end
  end

endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between the ALU result and data memory.
// Accepts one access at a time, runs a valid/ready memory handshake,
// formats store lanes / byte enables and extends load data.
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - core request handshake (ready only in IDLE)
//   req_we, ls_src, addr,    - access kind, size/sign code, effective
//   wdata                      address and store data
//   rsp_valid, load_data,    - one-cycle completion pulse with load result
//   bus_err                    and error flag (timeout / misalign trap)
//   stall                    - hold the pipeline while an access is live
//   mem_*                    - memory request/response channel
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently aligning them.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STRB_W         = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        ls_src,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   load_data,
  output logic              bus_err,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_be,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int OFF_W = $clog2(STRB_W);
  localparam bit IS64  = (XLEN == 64);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_t       state_q, state_d;
  logic             we_q, we_d;
  ls_mode_t         mode_q, mode_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [XLEN-1:0]  load_q, load_d;

  ls_mode_t         modeIn;
  int               sizeIn;
  logic [OFF_W-1:0] offIn;
  logic [OFF_W-1:0] offMaskIn;
  logic [OFF_W-1:0] offAligned;
  logic             timeoutHit;

  logic [STRB_W-1:0] beReq;
  logic [XLEN-1:0]   wdataRep;
  logic [XLEN-1:0]   loadExt;

  // Decode the incoming request; the offset mask is size-1 because every
  // legal size is a power of two.
  assign modeIn     = legalize_mode(ls_src, IS64);
  assign sizeIn     = size_bytes(modeIn);
  assign offIn      = addr[OFF_W-1:0];
  assign offMaskIn  = OFF_W'(sizeIn - 1);
  assign offAligned = offIn & ~offMaskIn;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalignIn;
  assign misalignIn = |(offIn & offMaskIn);
`endif

  // The counter holds the number of cycles already spent in REQ/WAIT, so
  // the final permitted cycle is the one where it reads TIMEOUT_CYCLES-1.
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .mode_i  (mode_q),
    .off_i   (addr_q[OFF_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_i (mem_rdata),
    .be_o    (beReq),
    .wdata_o (wdataRep),
    .rdata_o (loadExt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      mode_q  <= LS_W;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // A response always has priority over a timeout in the same cycle, and a
  // response without the matching request handshake in REQ is ignored.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    load_d  = load_q;

    case (state_q)
      IDLE: begin
        err_d  = 1'b0;
        load_d = '0;
        if (req_valid) begin
          we_d    = req_we;
          mode_d  = modeIn;
          addr_d  = {addr[XLEN-1:OFF_W], offAligned};
          wdata_d = wdata;
          cnt_d   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misalignIn) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end
      end

      REQ: begin
        if (mem_req_ready && mem_rsp_valid) begin
          state_d = RESP;
          load_d  = we_q ? '0 : loadExt;
        end else if (timeoutHit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          if (mem_req_ready) begin
            state_d = WAIT;
          end
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT: begin
        if (mem_rsp_valid) begin
          state_d = RESP;
          load_d  = we_q ? '0 : loadExt;
        end else if (timeoutHit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
        load_d  = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  // Memory-side fields are forced to zero outside REQ so the bus is quiet
  // whenever no request is being offered.
  assign req_ready     = (state_q == IDLE);
  assign stall         = (state_q != IDLE) | req_valid;
  assign rsp_valid     = (state_q == RESP);
  assign bus_err       = rsp_valid & err_q;
  assign load_data     = load_q;
  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = mem_req_valid & we_q;
  assign mem_addr      = mem_req_valid ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wdata     = mem_req_valid ? wdataRep : '0;
  assign mem_be        = mem_req_valid ? beReq : '0;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: scoreboard bench for lsu_mem_if with a 32-bit instance
// (short timeout) and a 64-bit instance (memory answering immediately).
module tb_lsu_mem_if;

  localparam int T = 4;

  typedef struct {
    logic [63:0] memAddr;
    logic [63:0] memWdata;
    logic [7:0]  be;
    logic        we;
    logic [63:0] loadData;
    bit          trap;
  } expT;

  typedef struct {
    logic [63:0] data;
    logic        err;
    longint      cyc;
  } rspT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        reqValid = 0, reqReady, reqWe = 0, rspValid, busErr, stall;
  logic [2:0]  lsSrc = 0;
  logic [31:0] addr = 0, wdata = 0, loadData, memAddr, memWdata, memRdata = 0;
  logic        memReqValid, memReqReady = 0, memWe, memRspValid = 0;
  logic [3:0]  memBe;

  logic        reqValid64 = 0, reqReady64, reqWe64 = 0, rspValid64, busErr64, stall64;
  logic [2:0]  lsSrc64 = 0;
  logic [63:0] addr64 = 0, wdata64 = 0, loadData64, memAddr64, memWdata64, memRdata64 = 0;
  logic        memReqValid64, memReqReady64 = 1'b1, memWe64, memRspValid64;
  logic [7:0]  memBe64;

  assign memRspValid64 = memReqValid64;

  lsu_mem_if #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
    .ls_src(lsSrc), .addr(addr), .wdata(wdata), .rsp_valid(rspValid), .load_data(loadData),
    .bus_err(busErr), .stall(stall), .mem_req_valid(memReqValid), .mem_req_ready(memReqReady),
    .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata), .mem_be(memBe),
    .mem_rsp_valid(memRspValid), .mem_rdata(memRdata));

  lsu_mem_if #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .req_valid(reqValid64), .req_ready(reqReady64), .req_we(reqWe64),
    .ls_src(lsSrc64), .addr(addr64), .wdata(wdata64), .rsp_valid(rspValid64),
    .load_data(loadData64), .bus_err(busErr64), .stall(stall64),
    .mem_req_valid(memReqValid64), .mem_req_ready(memReqReady64), .mem_we(memWe64),
    .mem_addr(memAddr64), .mem_wdata(memWdata64), .mem_be(memBe64),
    .mem_rsp_valid(memRspValid64), .mem_rdata(memRdata64));

  int     assertCount = 0;
  int     failCount = 0;
  longint cycleCount = 0;
  expT    memQ[$], mem64Q[$];
  rspT    rspQ[$], rsp64Q[$];
  expT    monMem, monMem64;
  rspT    monRsp, monRsp64;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on the architectural rules.
  function automatic expT model(input int xlen, input bit we, input logic [2:0] code,
                                input logic [63:0] a, input logic [63:0] wd,
                                input logic [63:0] rd);
    expT e;
    int sz, nb, off, offA;
    bit sgn;
    logic [63:0] lmask, xmask, v;
    nb = xlen / 8;
    case (code)
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: begin sz = 1; sgn = 1; end
      3'd3: begin sz = 2; sgn = 0; end
      3'd4: begin sz = 1; sgn = 0; end
      3'd5: begin sz = (xlen == 64) ? 8 : 4; sgn = 0; end
      3'd6: begin sz = 4; sgn = 0; end
      default: begin sz = 4; sgn = (xlen == 64); end
    endcase
    xmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    off = int'(a[2:0]) % nb;
    e.trap = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    e.trap = (off % sz) != 0;
`endif
    offA = off - (off % sz);
    e.memAddr = a - 64'(off);
    e.be = 8'(((1 << sz) - 1) << offA);
    e.we = we;
    lmask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    e.memWdata = 0;
    for (int j = 0; j < nb / sz; j++) e.memWdata |= (wd & lmask) << (8 * sz * j);
    v = (rd >> (8 * offA)) & lmask;
    if (sgn && v[8*sz-1]) v |= ~lmask;
    v &= xmask;
    e.loadData = (we || e.trap) ? 64'd0 : v;
    return e;
  endfunction

  // Memory timing: cycle 0 is the first cycle after accept. Ready is high
  // only in cycle rd, the response comes in cycle rd+rs; before rd stray
  // responses are sprinkled in and must be ignored.
  task automatic applyStimulus(input bit we, input logic [2:0] code, input logic [31:0] a,
                               input logic [31:0] wd, input int rd, input int rs,
                               input logic [31:0] rdat);
    expT e;
    rspT r;
    int k;
    bit done;
    e = model(32, we, code, {32'd0, a}, {32'd0, wd}, {32'd0, rdat});
    checkOutput("reqReadyBeforeAccept", {63'd0, reqReady}, 64'd1);
    reqValid = 1; reqWe = we; lsSrc = code; addr = a; wdata = wd;
    #1 checkOutput("stallOnAccept", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    reqValid = 0; addr = $urandom; wdata = $urandom;
    if (e.trap) begin
      r.data = 0; r.err = 1; r.cyc = cycleCount;
      rspQ.push_back(r);
      checkOutput("noMemReqOnTrap", {63'd0, memReqValid}, 64'd0);
    end else begin
      k = rd + rs;
      done = (k <= T - 1);
      if (rd <= T - 1) memQ.push_back(e);
      r.data = done ? e.loadData : 64'd0;
      r.err = !done;
      r.cyc = cycleCount + (done ? k : T - 1) + 1;
      rspQ.push_back(r);
      for (int cyc = 0; cyc <= T + 2; cyc++) begin
        memReqReady = (cyc == rd);
        memRspValid = (cyc == k) || (cyc < rd && $urandom_range(0, 1) == 1);
        memRdata = (cyc == k) ? rdat : $urandom;
        @(posedge clk); #1;
        if (rspValid) break;
      end
      memReqReady = 0; memRspValid = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus64(input bit we, input logic [2:0] code, input logic [63:0] a,
                                 input logic [63:0] wd, input logic [63:0] rdat);
    expT e;
    rspT r;
    e = model(64, we, code, a, wd, rdat);
    if (!e.trap) mem64Q.push_back(e);
    r.data = e.loadData; r.err = e.trap; r.cyc = 0;
    rsp64Q.push_back(r);
    memRdata64 = rdat;
    reqValid64 = 1; reqWe64 = we; lsSrc64 = code; addr64 = a; wdata64 = wd;
    @(posedge clk); #1;
    reqValid64 = 0;
    for (int i = 0; i < 8 && !rspValid64; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (memReqValid && memReqReady) begin
      if (memQ.size() == 0) begin
        assertCount++; failCount++;
        $display("[TB] FAIL unexpectedMemReq: got handshake at addr 0x%0h, expected none", memAddr);
      end else begin
        monMem = memQ.pop_front();
        checkOutput("memAddr", {32'd0, memAddr}, monMem.memAddr);
        checkOutput("memBe", {60'd0, memBe}, {56'd0, monMem.be});
        checkOutput("memWe", {63'd0, memWe}, {63'd0, monMem.we});
        if (monMem.we) checkOutput("memWdata", {32'd0, memWdata}, monMem.memWdata);
      end
    end
    if (rspValid) begin
      if (rspQ.size() == 0) begin
        assertCount++; failCount++;
        $display("[TB] FAIL unexpectedRsp: got rsp_valid=1, expected none");
      end else begin
        monRsp = rspQ.pop_front();
        checkOutput("loadData", {32'd0, loadData}, monRsp.data);
        checkOutput("busErr", {63'd0, busErr}, {63'd0, monRsp.err});
        checkOutput("rspCycle", cycleCount, monRsp.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (memReqValid64) begin
      if (mem64Q.size() == 0) begin
        assertCount++; failCount++;
        $display("[TB] FAIL unexpectedMemReq64: got addr 0x%0h, expected none", memAddr64);
      end else begin
        monMem64 = mem64Q.pop_front();
        checkOutput("memAddr64", memAddr64, monMem64.memAddr);
        checkOutput("memBe64", {56'd0, memBe64}, {56'd0, monMem64.be});
        if (monMem64.we) checkOutput("memWdata64", memWdata64, monMem64.memWdata);
      end
    end
    if (rspValid64) begin
      if (rsp64Q.size() == 0) begin
        assertCount++; failCount++;
        $display("[TB] FAIL unexpectedRsp64: got rsp_valid=1, expected none");
      end else begin
        monRsp64 = rsp64Q.pop_front();
        checkOutput("loadData64", loadData64, monRsp64.data);
        checkOutput("busErr64", {63'd0, busErr64}, {63'd0, monRsp64.err});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expT e;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReqReady", {63'd0, reqReady}, 64'd1);
    checkOutput("rstRspValid", {63'd0, rspValid}, 64'd0);
    checkOutput("rstBusErr", {63'd0, busErr}, 64'd0);
    checkOutput("rstLoadData", {32'd0, loadData}, 64'd0);
    checkOutput("rstMemReqValid", {63'd0, memReqValid}, 64'd0);
    checkOutput("rstMemBe", {60'd0, memBe}, 64'd0);
    checkOutput("rstMemAddr", {32'd0, memAddr}, 64'd0);
    checkOutput("rstMemWdata", {32'd0, memWdata}, 64'd0);
    checkOutput("rstMemWe", {63'd0, memWe}, 64'd0);
    rst = 0;

    applyStimulus(1, 3'b000, 32'h100, 32'h9BDF_C000, 0, 2, $urandom);
    applyStimulus(0, 3'b001, 32'h102, 32'h0, 1, 1, 32'h9BDF_C000);
    applyStimulus(0, 3'b011, 32'h102, 32'h0, 0, 0, 32'h9BDF_C000);
    applyStimulus(0, 3'b100, 32'h115, 32'h0, 0, 1, 32'h809B_DF40);
    applyStimulus(1, 3'b010, 32'h115, 32'h1234, 0, 0, 32'h0);
    applyStimulus(0, 3'b000, 32'h200, 32'h0, 0, 100, 32'h0);
    applyStimulus(0, 3'b000, 32'h204, 32'h0, 0, 0, 32'hCAFE_F00D);
    applyStimulus(1, 3'b001, 32'h208, 32'h5555, 50, 0, 32'h0);
    applyStimulus(0, 3'b000, 32'h101, 32'h0, 0, 0, 32'hA5A5_1234);
    applyStimulus(1, 3'b001, 32'h103, 32'hBEEF, 1, 0, 32'h0);

    // Reset while waiting for a response, then a late response in IDLE.
    e = model(32, 0, 3'b000, 64'h200, 64'h0, 64'h0);
    reqValid = 1; reqWe = 0; lsSrc = 3'b000; addr = 32'h200;
    @(posedge clk); #1;
    reqValid = 0;
    memQ.push_back(e);
    memReqReady = 1;
    @(posedge clk); #1;
    memReqReady = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checkOutput("reqReadyAfterMidReset", {63'd0, reqReady}, 64'd1);
    @(posedge clk); #1;
    memRspValid = 1; memRdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    memRspValid = 0;
    checkOutput("rspValidIgnoredLate", {63'd0, rspValid}, 64'd0);
    checkOutput("reqReadyIgnoredLate", {63'd0, reqReady}, 64'd1);

    for (int n = 0; n < 150; n++) begin
      applyStimulus($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom_range(0, T), $urandom_range(0, T - 1), $urandom);
    end

    applyStimulus64(0, 3'b101, 64'h8, 64'h0, 64'h0123_4567_89AB_CDEF);
    applyStimulus64(0, 3'b000, 64'hC, 64'h0, 64'h8000_0000_1234_5678);
    applyStimulus64(0, 3'b110, 64'hC, 64'h0, 64'h8000_0000_1234_5678);
    applyStimulus64(1, 3'b101, 64'h10, 64'hDEAD_BEEF_0BAD_F00D, 64'h0);
    applyStimulus64(1, 3'b001, 64'h16, 64'hBEEF, 64'h0);
    applyStimulus64(0, 3'b010, 64'h23, 64'h0, 64'h0000_0000_8000_0000);
    for (int n = 0; n < 30; n++) begin
      applyStimulus64($urandom_range(0, 1), 3'($urandom_range(0, 7)),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("memQDrained", 64'(memQ.size()), 64'd0);
    checkOutput("rspQDrained", 64'(rspQ.size()), 64'd0);
    checkOutput("mem64QDrained", 64'(mem64Q.size()), 64'd0);
    checkOutput("rsp64QDrained", 64'(rsp64Q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
